// File: rtl/ps2_key_rx.sv
// ps2_key_rx
//   PS/2 keyboard receiver. The raw clock and data pins are synchronised, the
//   clock is glitch-filtered, and 11-bit frames (start, 8 data LSB first, odd
//   parity, stop) are assembled. Prefix bytes (E0 extended, F0 release,
//   E1 pause sequence) are folded into a single key event word.
//
// Parameters
//   FILTER_LEN     : consecutive identical ps2_clk samples before the filtered
//                    level is allowed to change.
//   TIMEOUT_CYCLES : clk_sys cycles without a filtered falling edge that abort
//                    a partial frame (only with PS2_RX_TIMEOUT_EN defined).
//
// Build option
//   PS2_RX_TIMEOUT_EN : when defined, adds the inter-edge frame timeout.
//
// Ports
//   clk_sys  : system clock.
//   reset    : asynchronous, active-high reset.
//   ps2_clk  : raw PS/2 clock pin (asynchronous).
//   ps2_data : raw PS/2 data pin (asynchronous).
//   ps2_key  : [7:0] scancode, [8] extended, [9] pressed, [10] event toggle.
//   ps2_err  : one-cycle pulse per rejected frame.

module ps2_key_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        ps2_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);

  // ---------------------------------------------------------------------
  // Two-flop synchronisers; idle bus level is high.
  // ---------------------------------------------------------------------
  logic clk_meta_reg, clk_sync_reg;
  logic data_meta_reg, data_sync_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_meta_reg  <= 1'b1;
      clk_sync_reg  <= 1'b1;
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      clk_meta_reg  <= ps2_clk;
      clk_sync_reg  <= clk_meta_reg;
      data_meta_reg <= ps2_data;
      data_sync_reg <= data_meta_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Clock glitch filter: the counter tracks how long the synchronised clock
  // has disagreed with the filtered level; any agreement restarts it.
  // ---------------------------------------------------------------------
  logic           filt_clk_reg;
  logic [FCW-1:0] filt_cnt_reg;
  logic           filt_fall;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (clk_sync_reg == filt_clk_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_cnt_reg == FILT_LAST) begin
      filt_clk_reg <= clk_sync_reg;
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 1'b1;
    end
  end

  // High in the cycle the filtered clock is about to drop; data is taken now.
  assign filt_fall = filt_clk_reg && !clk_sync_reg && (filt_cnt_reg == FILT_LAST);

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  logic [1:0] state_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic       parity_reg;
  logic       stop_reg;
  logic       done_reg;
  logic       timeout_hit;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'd0;
      parity_reg  <= 1'b0;
      stop_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (timeout_hit) begin
        state_reg <= ST_IDLE;
      end else if (filt_fall) begin
        case (state_reg)
          ST_IDLE: begin
            if (!data_sync_reg) begin
              state_reg   <= ST_DATA;
              bit_cnt_reg <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_reg   <= {data_sync_reg, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_reg <= data_sync_reg;
            state_reg  <= ST_STOP;
          end
          default: begin
            stop_reg  <= data_sync_reg;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Optional inter-edge timeout
  // ---------------------------------------------------------------------
`ifdef PS2_RX_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] to_cnt_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      to_cnt_reg <= '0;
    end else if ((state_reg == ST_IDLE) || filt_fall || timeout_hit) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a falling edge.
  assign timeout_hit = (state_reg != ST_IDLE) && !filt_fall &&
                       (to_cnt_reg == TCW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Byte decode, one cycle after the stop bit is sampled. shift_reg is
  // stable here because the FSM sits in IDLE and cannot shift yet.
  // ---------------------------------------------------------------------
  logic       frame_ok;
  logic       frame_bad;
  logic       byte_ignored;
  logic       ext_reg;
  logic       rel_reg;
  logic [2:0] skip_reg;

  assign frame_ok  = done_reg && stop_reg && (^{shift_reg, parity_reg});
  assign frame_bad = done_reg && !frame_ok;

  always_comb begin
    byte_ignored = 1'b0;
    case (shift_reg)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: byte_ignored = 1'b1;
      default:                                   byte_ignored = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_key  <= 11'd0;
      ps2_err  <= 1'b0;
      ext_reg  <= 1'b0;
      rel_reg  <= 1'b0;
      skip_reg <= 3'd0;
    end else begin
      ps2_err <= 1'b0;
      if (frame_bad) begin
        ps2_err  <= 1'b1;
        ext_reg  <= 1'b0;
        rel_reg  <= 1'b0;
        skip_reg <= 3'd0;
      end else if (timeout_hit) begin
        ext_reg  <= 1'b0;
        rel_reg  <= 1'b0;
        skip_reg <= 3'd0;
      end else if (frame_ok) begin
        // The pause sequence swallows its trailing bytes before any other
        // interpretation, so E0/F0 inside it never reach the prefix flags.
        if (skip_reg != 3'd0) begin
          skip_reg <= skip_reg - 3'd1;
        end else if (shift_reg == 8'hE0) begin
          ext_reg <= 1'b1;
        end else if (shift_reg == 8'hF0) begin
          rel_reg <= 1'b1;
        end else if (shift_reg == 8'hE1) begin
          skip_reg <= 3'd7;
        end else if (!byte_ignored) begin
          ps2_key <= {~ps2_key[10], ~rel_reg, ext_reg, shift_reg};
          ext_reg <= 1'b0;
          rel_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx
//   Directed bench for ps2_key_rx. A reference model of the prefix/skip
//   decoding pushes expected ps2_key words into a queue before each frame is
//   driven; a monitor pops and compares whenever ps2_key changes.

module tb_ps2_key_rx;

  localparam int FLEN = 4;
  localparam int TOUT = 300;
  localparam int HALF = 20;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        ps2_err;

  int checks = 0;
  int errors = 0;

  ps2_key_rx #(
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .ps2_err  (ps2_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Scoreboard and reference model state
  logic [10:0] exp_q[$];
  int          err_pulses = 0;
  logic        m_ext  = 1'b0;
  logic        m_rel  = 1'b0;
  int          m_skip = 0;
  int          m_err  = 0;
  logic [10:0] m_key  = 11'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compares every ps2_key change against the queue head and
  // checks that ps2_err never stays high two cycles in a row.
  initial begin
    logic [10:0] prev_key;
    logic [10:0] exp_key;
    logic        prev_err;
    prev_key = '0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_key = ps2_key;
        prev_err = ps2_err;
      end else begin
        if (ps2_key !== prev_key) begin
          if (exp_q.size() == 0) begin
            check("unexpected_key", {21'd0, ps2_key}, {21'd0, prev_key});
          end else begin
            exp_key = exp_q.pop_front();
            check("key_event", {21'd0, ps2_key}, {21'd0, exp_key});
            $display("event: ps2_key=%03h expected=%03h", ps2_key, exp_key);
          end
          prev_key = ps2_key;
        end
        if (ps2_err) begin
          check("err_width", {31'd0, prev_err}, 32'd0);
          if (!prev_err) err_pulses++;
        end
        prev_err = ps2_err;
      end
    end
  end

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_err++;
      m_ext  = 1'b0;
      m_rel  = 1'b0;
      m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      // dropped, flags kept
    end else begin
      m_key = {~m_key[10], ~m_rel, m_ext, b};
      exp_q.push_back(m_key);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk_sys);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk_sys);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (FLEN - 1) @(negedge clk_sys);
      ps2_clk = 1'b1;
    end
    repeat (HALF / 2) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good, input int nbits, input int glitch_at);
    logic [10:0] bits;
    bits = {1'b1, (good ? ~^b : ^b), b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], (i == glitch_at));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check("drain", exp_q.size(), 0);
    check("err_count", err_pulses, m_err);
  endtask

  task automatic send(input logic [7:0] b, input bit good);
    model_byte(b, good);
    send_frame(b, good, 11, -1);
    drain();
    $display("frame %02h good=%0d -> ps2_key=%03h err_pulses=%0d", b, good, ps2_key, err_pulses);
  endtask

  initial begin
    logic [7:0] pause_seq[8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    // Reset state
    repeat (5) @(negedge clk_sys);
    check("reset_key", {21'd0, ps2_key}, 32'd0);
    check("reset_err", {31'd0, ps2_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);

    // Press / release
    send(8'h1C, 1'b1);
    check("press_1C", {21'd0, ps2_key}, 32'h61C);
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    check("release_1C", {21'd0, ps2_key}, 32'h01C);

    // Extended press / release
    send(8'hE0, 1'b1);
    send(8'h75, 1'b1);
    check("ext_press_75", {21'd0, ps2_key}, 32'h775);
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h75, 1'b1);
    check("ext_release_75", {21'd0, ps2_key}, 32'h175);

    // Parity error, then release of 29
    send(8'h29, 1'b0);
    check("err_key_hold", {21'd0, ps2_key}, 32'h175);
    check("err_one_pulse", err_pulses, 1);
    send(8'hF0, 1'b1);
    send(8'h29, 1'b1);
    check("release_29", {21'd0, ps2_key}, 32'h429);

    // Sub-threshold clock glitch in the middle of a frame
    model_byte(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1, 11, 4);
    drain();
    check("glitch_5A", {21'd0, ps2_key}, 32'h25A);
    $display("glitch frame 5A -> ps2_key=%03h", ps2_key);

    // Pause sequence is swallowed, following 1C press delivered
    for (int i = 0; i < 8; i++) send(pause_seq[i], 1'b1);
    check("pause_hold", {21'd0, ps2_key}, 32'h25A);
    send(8'h1C, 1'b1);
    check("after_pause_1C", {21'd0, ps2_key}, 32'h61C);

    // Reset in the middle of a frame, prefix pending
    send(8'hE0, 1'b1);
    send_frame(8'h33, 1'b1, 4, -1);
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("midreset_key", {21'd0, ps2_key}, 32'd0);
    check("midreset_err", {31'd0, ps2_err}, 32'd0);
    exp_q.delete();
    m_key = 11'd0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_skip = 0;
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);
    send(8'h1C, 1'b1);
    check("post_reset_1C", {21'd0, ps2_key}, 32'h61C);

`ifdef PS2_RX_TIMEOUT_EN
    // Partial frame abandoned by the timeout; E0 prefix must be cleared
    send(8'hE0, 1'b1);
    send_frame(8'h5A, 1'b1, 5, -1);
    repeat (TOUT + 20) @(negedge clk_sys);
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_skip = 0;
    check("timeout_no_err", err_pulses, m_err);
    send(8'h5A, 1'b1);
    check("timeout_5A", {21'd0, ps2_key}, 32'h25A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive identical ps2_clk samples needed before the filtered level changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 60000: the clk_sys cycles without a filtered falling edge that abort a frame (only when PS2_RX_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk_sys, input, 1: the single system clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1: raw PS/2 clock pin, asynchronous to clk_sys.
REQ-006 SHALL have port ps2_data, input, 1: raw PS/2 data pin, asynchronous to clk_sys.
REQ-007 SHALL have port ps2_key, output, 11: [7:0] scancode, [8] extended (E0 prefix), [9] pressed, [10] toggles once per delivered event.
REQ-008 SHALL have port ps2_err, output, 1: one-cycle pulse on each rejected frame.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers (both reset to 1).
REQ-010 SHALL change the filtered clock only after FILTER_LEN consecutive synchronised samples at the new level; shorter glitches are ignored.
REQ-011 SHALL sample synchronised ps2_data in the cycle where the filtered clock falls from 1 to 0.
REQ-012 SHALL use an FSM with states IDLE, DATA, PARITY and STOP, and a 3-bit data counter.
REQ-013 IDLE: a sampled 0 SHALL move to DATA with counter=0; a sampled 1 SHALL leave the FSM in IDLE.
REQ-014 DATA: SHALL shift bits in LSB first; after the 8th bit (counter=7) SHALL go to PARITY.
REQ-015 PARITY: SHALL store the bit and go to STOP.
REQ-016 STOP: SHALL go to IDLE; the frame is valid only if the stop bit is 1 and the 8 data bits plus parity contain an odd number of 1s.
REQ-017 Invalid frame: SHALL pulse ps2_err for 1 cycle, discard the byte, clear the ext and rel flags and the skip counter, and leave ps2_key unchanged.
REQ-018 Valid byte E0: SHALL set ext and produce no output.
REQ-019 Valid byte F0: SHALL set rel and produce no output.
REQ-020 Valid byte E1: SHALL load a skip counter with 7; while skip counter>0, each valid byte SHALL decrement it and be dropped with no output.
REQ-021 Valid bytes FA, AA, EE, FE, 00 and FF: SHALL be dropped without changing ext or rel.
REQ-022 Any other valid byte: the cycle after the stop-bit sample, SHALL update ps2_key[7:0]=byte, [8]=ext, [9]=~rel, [10]=~[10], then clear ext and rel.
REQ-023 Latency SHALL be exactly 1 clk_sys cycle from the stop-bit sampling edge to the ps2_key update; ps2_key SHALL hold between events.
REQ-024 Prefix flags SHALL survive across frames until a scancode is delivered or an error, timeout or reset occurs.

Reset
REQ-025 While reset=1: ps2_key=0, ps2_err=0, FSM=IDLE, filtered clock=1, filter counter=0, ext=rel=0, skip=0, timeout counter=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release the next start bit SHALL begin a fresh frame.

Configuration
REQ-027 With PS2_RX_TIMEOUT_EN defined: outside IDLE, a counter SHALL count cycles since the last filtered falling edge; at TIMEOUT_CYCLES it SHALL force IDLE and clear ext, rel and skip, with no ps2_err pulse.
REQ-028 Without PS2_RX_TIMEOUT_EN: no timeout logic SHALL exist, and a partial frame SHALL wait indefinitely for further edges.

Verification
REQ-029 After reset, send frame 1C -> ps2_key=0x61C; then send F0,1C -> ps2_key=0x01C.
REQ-030 From ps2_key=0x01C, send E0,75 -> ps2_key=0x775; then send E0,F0,75 -> ps2_key=0x175.
REQ-031 Send 29 with even parity -> ps2_err high for exactly 1 cycle, ps2_key unchanged; then send F0 and valid 29 -> release event with [8]=0.
REQ-032 Inject a ps2_clk low glitch of FILTER_LEN-1 cycles mid-frame -> no extra bit; frame 5A decoded normally.
REQ-033 With PS2_RX_TIMEOUT_EN: send 5 bits, idle TIMEOUT_CYCLES+1 cycles, then send full frame 5A -> 5A delivered with [10] toggled and [8]=0.
REQ-034 Send E1,14,77,E1,F0,14,F0,77 then 1C -> only the 1C press changes ps2_key.
